// File: rtl/pic_dbg_ctrl.sv
// Debug run-control and register-file access controller for the PIC core.
// Optional hardware breakpoint is built when PIC_DBG_BREAKPOINT_EN is defined.
module pic_dbg_ctrl (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] pc_addr,
    input  logic       halt_req,
    input  logic       resume,
    input  logic       step,
    input  logic       acc_req,
    input  logic       acc_we,
    input  logic [4:0] acc_addr,
    input  logic [7:0] acc_wdata,
    output logic       acc_ack,
    output logic [7:0] acc_rdata,
    input  logic [7:0] file_rdata,
    output logic       core_en,
    output logic       file_sel,
    output logic [4:0] file_addr,
    output logic [7:0] file_wdata,
    output logic       file_wen,
    output logic       file_oen,
    output logic       halted,
    input  logic [8:0] bp_addr,
    input  logic       bp_en,
    output logic       bp_hit
);

    localparam logic [2:0] RUN    = 3'd0;
    localparam logic [2:0] HALTED = 3'd1;
    localparam logic [2:0] STEP   = 3'd2;
    localparam logic [2:0] ACC_RD = 3'd3;
    localparam logic [2:0] ACC_WR = 3'd4;

    logic [2:0] state;
    logic       bp_match;
    logic       acc_start;
    logic       leave_halt;
    logic       sfr_addr;

    // A request arriving in the ack cycle is the tail of the previous access.
    assign acc_start  = (state == HALTED) && acc_req && !acc_ack;
    assign leave_halt = (state == HALTED) && !acc_start && (step || (resume && !halt_req));
    assign sfr_addr   = (acc_addr[4:3] == 2'b00);

`ifdef PIC_DBG_BREAKPOINT_EN
    logic bp_skip;
    logic bp_hit_q;

    assign bp_match = (state == RUN) && bp_en && (pc_addr == bp_addr) && !bp_skip;
    assign bp_hit   = bp_hit_q;

    // bp_skip lets the instruction sitting at the breakpoint run once after leaving HALTED.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bp_skip  <= 1'b0;
            bp_hit_q <= 1'b0;
        end else begin
            bp_skip <= leave_halt;
            if (leave_halt)
                bp_hit_q <= 1'b0;
            else if (bp_match)
                bp_hit_q <= 1'b1;
        end
    end
`else
    logic unused_bp;

    assign unused_bp = ^{bp_addr, bp_en};
    assign bp_match  = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            acc_ack   <= 1'b0;
            acc_rdata <= 8'h00;
        end else begin
            acc_ack <= 1'b0;
            case (state)
                RUN: begin
                    if (halt_req || bp_match)
                        state <= HALTED;
                end
                HALTED: begin
                    if (acc_start)
                        state <= acc_we ? ACC_WR : ACC_RD;
                    else if (step)
                        state <= STEP;
                    else if (resume && !halt_req)
                        state <= RUN;
                end
                STEP: begin
                    state <= HALTED;
                end
                ACC_RD: begin
                    acc_rdata <= sfr_addr ? 8'h00 : file_rdata;
                    acc_ack   <= 1'b1;
                    state     <= HALTED;
                end
                ACC_WR: begin
                    acc_ack <= 1'b1;
                    state   <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    // Bus overrides are decoded from state alone so reset releases them at once.
    assign core_en    = ((state == RUN) && !bp_match) || (state == STEP);
    assign halted     = !((state == RUN) || (state == STEP));
    assign file_sel   = (state == ACC_RD) || (state == ACC_WR);
    assign file_addr  = file_sel ? acc_addr : 5'd0;
    assign file_wdata = (state == ACC_WR) ? acc_wdata : 8'h00;
    assign file_wen   = (state == ACC_WR) && !sfr_addr;
    assign file_oen   = (state == ACC_RD) && !sfr_addr;

endmodule

// File: tb/tb_pic_dbg_ctrl.sv
// Scoreboard bench for pic_dbg_ctrl with a small PC and register-file model around it.
// The breakpoint section follows PIC_DBG_BREAKPOINT_EN.
module tb_pic_dbg_ctrl;

    logic       clock;
    logic       reset;
    logic [8:0] pc_addr;
    logic       halt_req;
    logic       resume;
    logic       step;
    logic       acc_req;
    logic       acc_we;
    logic [4:0] acc_addr;
    logic [7:0] acc_wdata;
    logic       acc_ack;
    logic [7:0] acc_rdata;
    logic [7:0] file_rdata;
    logic       core_en;
    logic       file_sel;
    logic [4:0] file_addr;
    logic [7:0] file_wdata;
    logic       file_wen;
    logic       file_oen;
    logic       halted;
    logic [8:0] bp_addr;
    logic       bp_en;
    logic       bp_hit;

    logic [7:0] regs [32];
    logic [7:0] sb_q [$];
    int         total_checks;
    int         passed_checks;
    logic [8:0] saved_pc;

    pic_dbg_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .pc_addr    (pc_addr),
        .halt_req   (halt_req),
        .resume     (resume),
        .step       (step),
        .acc_req    (acc_req),
        .acc_we     (acc_we),
        .acc_addr   (acc_addr),
        .acc_wdata  (acc_wdata),
        .acc_ack    (acc_ack),
        .acc_rdata  (acc_rdata),
        .file_rdata (file_rdata),
        .core_en    (core_en),
        .file_sel   (file_sel),
        .file_addr  (file_addr),
        .file_wdata (file_wdata),
        .file_wen   (file_wen),
        .file_oen   (file_oen),
        .halted     (halted),
        .bp_addr    (bp_addr),
        .bp_en      (bp_en),
        .bp_hit     (bp_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program counter advances only while the core is enabled.
    always @(posedge clock or negedge reset) begin
        if (!reset)
            pc_addr <= 9'd0;
        else if (core_en)
            pc_addr <= pc_addr + 9'd1;
    end

    always @(posedge clock) begin
        if (reset && file_wen)
            regs[file_addr] <= file_wdata;
    end

    assign file_rdata = file_oen ? regs[file_addr] : 8'hEE;

    task automatic check_output(input string name, input int actual, input int expected);
        total_checks++;
        if (actual == expected)
            passed_checks++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Monitor: every ack pops the next expected read-data value.
    always @(negedge clock) begin
        if (reset && acc_ack) begin
            if (sb_q.size() == 0) begin
                total_checks++;
                $display("[TB] FAIL unexpected_ack: got ack, expected no pending access");
            end else begin
                check_output("acc_rdata", acc_rdata, sb_q.pop_front());
            end
        end
    end

    task automatic apply_stimulus(input logic h, input logic r, input logic s);
        @(negedge clock);
        halt_req = h;
        resume   = r;
        step     = s;
    endtask

    task automatic apply_access(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                                input logic [7:0] exp_rdata, input bit hold);
        int  cycles;
        bit  reaches_file;
        @(negedge clock);
        acc_req   = 1'b1;
        acc_we    = we;
        acc_addr  = addr;
        acc_wdata = wdata;
        sb_q.push_back(exp_rdata);
        reaches_file = (addr >= 5'h08);
        @(negedge clock);
        check_output("acc_file_sel", file_sel, 1);
        check_output("acc_file_addr", file_addr, addr);
        check_output("acc_file_wen", file_wen, we && reaches_file);
        check_output("acc_file_oen", file_oen, !we && reaches_file);
        if (we && reaches_file)
            check_output("acc_file_wdata", file_wdata, wdata);
        cycles = 1;
        while (!acc_ack && cycles < 8) begin
            @(negedge clock);
            cycles++;
        end
        check_output("acc_latency", cycles, 2);
        if (hold) begin
            @(negedge clock);
            check_output("no_reaccept_in_ack", file_sel, 0);
        end
        acc_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        for (int i = 0; i < 32; i++) regs[i] = 8'h00;
        regs[3]    = 8'hA5;
        regs[5'h11] = 8'h3C;
        reset     = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        step      = 1'b0;
        acc_req   = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = 5'd0;
        acc_wdata = 8'h00;
        bp_addr   = 9'h020;
        bp_en     = 1'b0;

        repeat (2) @(negedge clock);
        check_output("rst_core_en", core_en, 1);
        check_output("rst_halted", halted, 0);
        check_output("rst_acc_ack", acc_ack, 0);
        check_output("rst_file_sel", file_sel, 0);
        check_output("rst_file_wen", file_wen, 0);
        check_output("rst_file_oen", file_oen, 0);
        check_output("rst_bp_hit", bp_hit, 0);
        check_output("rst_acc_rdata", acc_rdata, 0);
        reset = 1'b1;
        repeat (3) @(negedge clock);

        // Halt with a one-cycle pulse; a pending request must be ignored while running.
        acc_req  = 1'b1;
        acc_we   = 1'b0;
        acc_addr = 5'h10;
        @(negedge clock);
        check_output("run_ignores_acc", file_sel, 0);
        acc_req = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("halt_core_en", core_en, 0);
        check_output("halt_halted", halted, 1);
        saved_pc = pc_addr;
        repeat (3) @(negedge clock);
        check_output("halt_pc_frozen", pc_addr, saved_pc);

        // Resume while halt_req is still high is ignored.
        apply_stimulus(1'b1, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("resume_blocked", halted, 1);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("resume_core_en", core_en, 1);
        check_output("resume_halted", halted, 0);
        @(negedge clock);
        check_output("resume_pc_adv", pc_addr, saved_pc + 9'd1);

        // Single step from HALTED.
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        saved_pc = pc_addr;
        apply_stimulus(1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("step_core_en", core_en, 1);
        check_output("step_halted", halted, 0);
        @(negedge clock);
        check_output("step_core_en_off", core_en, 0);
        check_output("step_halted_back", halted, 1);
        check_output("step_pc_adv", pc_addr, saved_pc + 9'd1);

        // Breakpoint at 0x020 from a halted core.
        bp_en = 1'b1;
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64 && pc_addr != 9'h020; i++) @(negedge clock);
        check_output("bp_pc_reached", pc_addr, 9'h020);
`ifdef PIC_DBG_BREAKPOINT_EN
        check_output("bp_core_en_gated", core_en, 0);
        @(negedge clock);
        check_output("bp_halted", halted, 1);
        check_output("bp_hit_set", bp_hit, 1);
        check_output("bp_pc_held", pc_addr, 9'h020);
        apply_stimulus(1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("bp_skip_core_en", core_en, 1);
        check_output("bp_hit_cleared", bp_hit, 0);
        @(negedge clock);
        check_output("bp_pc_past", pc_addr, 9'h021);
        check_output("bp_no_retrigger", halted, 0);
`else
        check_output("bp_off_core_en", core_en, 1);
        @(negedge clock);
        check_output("bp_off_pc_past", pc_addr, 9'h021);
        check_output("bp_off_hit", bp_hit, 0);
        check_output("bp_off_halted", halted, 0);
`endif
        bp_en = 1'b0;
        apply_stimulus(1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_output("halt2_halted", halted, 1);

        // Register-file accesses, expected read data written by hand.
        apply_access(1'b1, 5'h10, 8'h5A, 8'h00, 1'b0);
        apply_access(1'b0, 5'h10, 8'h00, 8'h5A, 1'b0);
        apply_access(1'b0, 5'h11, 8'h00, 8'h3C, 1'b1);
        apply_access(1'b1, 5'h03, 8'hFF, 8'h3C, 1'b0);
        apply_access(1'b0, 5'h03, 8'h00, 8'h00, 1'b0);
        @(negedge clock);
        check_output("regs_10_written", regs[5'h10], 8'h5A);
        check_output("regs_03_untouched", regs[3], 8'hA5);

        // Reset in the middle of a write must abort it.
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = 5'h12;
        acc_wdata = 8'h77;
        @(negedge clock);
        check_output("wr_abort_wen_before", file_wen, 1);
        #2 reset = 1'b0;
        #1;
        check_output("wr_abort_wen_drop", file_wen, 0);
        check_output("wr_abort_sel_drop", file_sel, 0);
        acc_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_output("post_rst_core_en", core_en, 1);
        check_output("post_rst_halted", halted, 0);
        check_output("post_rst_acc_rdata", acc_rdata, 0);
        check_output("wr_abort_no_write", regs[5'h12], 8'h00);
        check_output("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
